// File: rtl/simon_fsm_param.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : simon_fsm_param                                                 |
// | Purpose  : Simon Says game controller: launch, playback, input, fail, end  |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module simon_fsm_param #(
  parameter int NUM_COLOURS    = 4,
  parameter int MAX_ROUNDS     = 32,
  parameter int SPEEDUP_EVERY  = 5,
  parameter int SPEED_W        = 3,
  parameter int FAIL_FLASHES   = 3,
  parameter int LIVES          = 0,
  parameter int TIMEOUT_PULSES = 8
) (
  input  logic                                         clk,
  input  logic                                         reset,
  input  logic [1:0]                                   launch_keys,
  input  logic [NUM_COLOURS-1:0]                       player_input,
  input  logic                                         pulse,
  input  logic                                         result,
  output logic                                         start,
  output logic                                         rst_seedgen,
  output logic                                         load_colour,
  output logic                                         load_speed,
  output logic                                         flash_clk,
  output logic [$clog2(MAX_ROUNDS+1)-1:0]              check_round,
  output logic [SPEED_W-1:0]                           speed,
  output logic [$clog2(MAX_ROUNDS+1)-1:0]              current_round,
  output logic [((LIVES > 0) ? $clog2(LIVES+1) : 1)-1:0] lives_left,
  output logic                                         win,
  output logic                                         game_over
);

  localparam int RW = $clog2(MAX_ROUNDS + 1);
  localparam int LW = (LIVES > 0) ? $clog2(LIVES + 1) : 1;
  localparam int TW = (TIMEOUT_PULSES > 0) ? $clog2(TIMEOUT_PULSES + 1) : 1;
  localparam int SW = (SPEEDUP_EVERY > 1) ? $clog2(SPEEDUP_EVERY) : 1;
  localparam int FW = 3;
  localparam logic [NUM_COLOURS-1:0] ONE_HOT_LSB = NUM_COLOURS'(1);

  typedef enum logic [4:0] {
    S_READY1        = 5'd0,
    S_RST_SEEDGEN   = 5'd1,
    S_READY12       = 5'd2,
    S_START_RNG     = 5'd3,
    S_HOLD          = 5'd4,
    S_ADD_CLR       = 5'd5,
    S_INC_SPEED     = 5'd6,
    S_IS_NEXT_PULSE = 5'd7,
    S_PULSE_ON      = 5'd8,
    S_PULSE_OFF     = 5'd9,
    S_PREP          = 5'd10,
    S_PLAYER_TURN   = 5'd11,
    S_GOOD_TURN     = 5'd12,
    S_NEXT_SEG      = 5'd13,
    S_DESELECT      = 5'd14,
    S_FAIL_ON       = 5'd15,
    S_FAIL_ON_WAIT  = 5'd16,
    S_FAIL_OFF      = 5'd17,
    S_FAIL_OFF_WAIT = 5'd18,
    S_RETRY         = 5'd19,
    S_WIN           = 5'd20,
    S_END           = 5'd21
  } state_t;

  state_t          state_q;
  logic [RW-1:0]   check_round_q;
  logic [RW-1:0]   current_round_q;
  logic [SPEED_W-1:0] speed_q;
  logic [LW-1:0]   lives_q;
  logic [FW-1:0]   fail_q;
  logic [TW-1:0]   timeout_q;
  logic [SW-1:0]   speedup_q;
  logic            win_q;

  logic [RW-1:0]   round_d;
  logic [TW-1:0]   timeout_d;
  logic            press_any;
  logic            press_multi;

  assign round_d     = current_round_q + RW'(1);
  assign timeout_d   = timeout_q + TW'(1);
  assign press_any   = |player_input;
  // Clearing the lowest set bit leaves something only when two or more are high.
  assign press_multi = |(player_input & (player_input - ONE_HOT_LSB));

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q         <= S_READY1;
      check_round_q   <= '0;
      current_round_q <= '0;
      speed_q         <= '0;
      lives_q         <= LW'(LIVES);
      fail_q          <= '0;
      timeout_q       <= '0;
      speedup_q       <= '0;
      win_q           <= 1'b0;
    end else begin
      case (state_q)
        S_READY1: begin
          check_round_q   <= '0;
          current_round_q <= '0;
          speed_q         <= '0;
          lives_q         <= LW'(LIVES);
          fail_q          <= '0;
          timeout_q       <= '0;
          speedup_q       <= '0;
          win_q           <= 1'b0;
          if (launch_keys[0]) state_q <= S_RST_SEEDGEN;
        end
        S_RST_SEEDGEN: state_q <= S_READY12;
        S_READY12:     if (launch_keys == 2'b11) state_q <= S_START_RNG;
        S_START_RNG:   state_q <= S_HOLD;
        S_HOLD:        if (launch_keys == 2'b00) state_q <= S_ADD_CLR;
        S_ADD_CLR: begin
          current_round_q <= round_d;
          check_round_q   <= round_d;
          // speedup_q tracks the new round number modulo SPEEDUP_EVERY
          if (speedup_q == SW'(SPEEDUP_EVERY - 1)) begin
            speedup_q <= '0;
            state_q   <= S_INC_SPEED;
          end else begin
            speedup_q <= speedup_q + SW'(1);
            state_q   <= S_IS_NEXT_PULSE;
          end
        end
        S_INC_SPEED: begin
          if (speed_q != '1) speed_q <= speed_q + SPEED_W'(1);
          state_q <= S_IS_NEXT_PULSE;
        end
        S_IS_NEXT_PULSE: begin
          if (pulse) state_q <= (check_round_q == '0) ? S_PREP : S_PULSE_ON;
        end
        S_PULSE_ON: if (pulse) state_q <= S_PULSE_OFF;
        S_PULSE_OFF: begin
          check_round_q <= check_round_q - RW'(1);
          state_q       <= S_IS_NEXT_PULSE;
        end
        S_PREP: begin
          check_round_q <= current_round_q;
          timeout_q     <= '0;
          state_q       <= S_PLAYER_TURN;
        end
        S_PLAYER_TURN: begin
          if (check_round_q == '0) begin
            if (current_round_q == RW'(MAX_ROUNDS)) begin
              win_q   <= 1'b1;
              state_q <= S_WIN;
            end else begin
              state_q <= S_ADD_CLR;
            end
          end else if (press_multi) begin
            state_q <= S_FAIL_ON;
          end else if (press_any) begin
            state_q <= S_GOOD_TURN;
          end else if ((TIMEOUT_PULSES != 0) && pulse) begin
            timeout_q <= timeout_d;
            if (timeout_d == TW'(TIMEOUT_PULSES)) state_q <= S_FAIL_ON;
          end
        end
        S_GOOD_TURN: state_q <= result ? S_NEXT_SEG : S_FAIL_ON;
        S_NEXT_SEG: begin
          if (check_round_q != '0) check_round_q <= check_round_q - RW'(1);
          timeout_q <= '0;
          state_q   <= S_DESELECT;
        end
        S_DESELECT: if (!press_any) state_q <= S_PLAYER_TURN;
        S_FAIL_ON: begin
          fail_q  <= fail_q + FW'(1);
          state_q <= S_FAIL_ON_WAIT;
        end
        S_FAIL_ON_WAIT: if (pulse) state_q <= S_FAIL_OFF;
        S_FAIL_OFF: begin
          if (fail_q == FW'(FAIL_FLASHES)) begin
            if (lives_q != '0) begin
              state_q <= S_RETRY;
            end else begin
              // Game over reports rounds actually completed.
              if (current_round_q != '0) current_round_q <= current_round_q - RW'(1);
              state_q <= S_END;
            end
          end else begin
            state_q <= S_FAIL_OFF_WAIT;
          end
        end
        S_FAIL_OFF_WAIT: if (pulse) state_q <= S_FAIL_ON;
        S_RETRY: begin
          lives_q       <= lives_q - LW'(1);
          fail_q        <= '0;
          timeout_q     <= '0;
          check_round_q <= current_round_q;
          state_q       <= S_IS_NEXT_PULSE;
        end
        S_WIN: state_q <= S_END;
        S_END: state_q <= S_END;
        default: state_q <= S_READY1;
      endcase
    end
  end

  assign rst_seedgen   = (state_q == S_RST_SEEDGEN);
  assign start         = (state_q == S_START_RNG);
  assign load_colour   = (state_q == S_ADD_CLR);
  assign load_speed    = (state_q == S_INC_SPEED);
  assign flash_clk     = (state_q == S_PULSE_ON) || (state_q == S_FAIL_ON) ||
                         (state_q == S_FAIL_ON_WAIT);
  assign game_over     = (state_q == S_END);
  assign win           = win_q;
  assign check_round   = check_round_q;
  assign current_round = current_round_q;
  assign speed         = speed_q;
  assign lives_left    = lives_q;

endmodule
`default_nettype wire
